// File: rtl/blk_mem_gen_pkg.sv
// Shared definitions for the simple-dual-port block RAM and its post-reset clear sequencer.
package blk_mem_gen_pkg;

  localparam string WM_READ_FIRST  = "READ_FIRST";
  localparam string WM_WRITE_FIRST = "WRITE_FIRST";

  typedef enum logic [0:0] {
    CLEAR,
    READY
  } clr_state_e;

  function automatic int unsigned byte_count(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/blk_mem_gen_sdp_ram_if.sv
// Port bundle of the simple-dual-port RAM: byte-enabled write port A, pipelined read port B.
interface blk_mem_gen_sdp_ram_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);

  logic [DATA_WIDTH/8-1:0] wea;
  logic [ADDR_WIDTH-1:0]   addra;
  logic [DATA_WIDTH-1:0]   dina;
  logic                    enb;
  logic [ADDR_WIDTH-1:0]   addrb;
  logic [DATA_WIDTH-1:0]   doutb;
  logic                    doutb_valid;
  logic                    init_busy;

  modport master (
    output wea, addra, dina, enb, addrb,
    input  doutb, doutb_valid, init_busy
  );

  modport slave (
    input  wea, addra, dina, enb, addrb,
    output doutb, doutb_valid, init_busy
  );

endinterface

// File: rtl/blk_mem_gen_clear_ctrl.sv
// Post-reset clear sequencer: sweeps every address once, writing zero, then reports ready.
module blk_mem_gen_clear_ctrl
  import blk_mem_gen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clka,
  input  logic                  rsta,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_en
);

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= '0;
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          // Last address is being zeroed on this edge.
          if (&cnt_q) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign init_busy = busy_q;
  assign clr_addr  = cnt_q;
  assign clr_en    = (state_q == CLEAR) && !rsta;

endmodule

// File: rtl/blk_mem_gen_sdp_ram.sv
// Single-clock simple-dual-port RAM: byte-enabled writes, 1/2-cycle registered reads with valid
// strobe, selectable same-address collision policy and optional zero-fill after reset.
module blk_mem_gen_sdp_ram
  import blk_mem_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned READ_LATENCY   = 1,
  parameter string       WRITE_MODE     = "READ_FIRST",
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic                  clka,
  input logic                  rsta,
  blk_mem_gen_sdp_ram_if.slave mem_if
);

  localparam int          NB         = int'(byte_count(DATA_WIDTH));
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
  localparam bit          WriteFirst = (WRITE_MODE == WM_WRITE_FIRST);

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if ((WRITE_MODE != WM_READ_FIRST) && (WRITE_MODE != WM_WRITE_FIRST)) begin : g_bad_mode
    $error("WRITE_MODE must be READ_FIRST or WRITE_FIRST");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  logic                  init_busy;
  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;

  blk_mem_gen_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clka      (clka),
    .rsta      (rsta),
    .init_busy (init_busy),
    .clr_addr  (clr_addr),
    .clr_en    (clr_en)
  );

  assign mem_if.init_busy = init_busy;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  usr_en;
  logic [NB-1:0]         usr_be;
  logic                  rd_req;
  logic [NB-1:0]         wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_word;

  assign usr_en = !rsta && !init_busy;
  assign usr_be = usr_en ? mem_if.wea : '0;
  assign rd_req = usr_en && mem_if.enb;

  // The clear sequencer owns the write port while it runs.
  always_comb begin
    wr_be   = usr_be;
    wr_addr = mem_if.addra;
    wr_data = mem_if.dina;
    if (clr_en) begin
      wr_be   = '1;
      wr_addr = clr_addr;
      wr_data = '0;
    end
  end

  always_ff @(posedge clka) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Same-address bypass: enabled bytes of the in-flight write replace the stored word.
  always_comb begin
    rd_word = mem_q[mem_if.addrb];
    if (WriteFirst && (mem_if.addra == mem_if.addrb)) begin
      for (int i = 0; i < NB; i++) begin
        if (usr_be[i]) rd_word[8*i +: 8] = mem_if.dina[8*i +: 8];
      end
    end
  end

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  always_ff @(posedge clka) begin
    if (rsta) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_req;
      if (rd_req) s1_data_q <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clka) begin
      if (rsta) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign mem_if.doutb       = s2_data_q;
    assign mem_if.doutb_valid = s2_valid_q;
  end else begin : g_lat1
    assign mem_if.doutb       = s1_data_q;
    assign mem_if.doutb_valid = s1_valid_q;
  end

endmodule

// File: tb/tb_blk_mem_gen_sdp_ram.sv
// Scoreboard bench: two instances (latency 1 read-first, latency 2 write-first) share one stimulus.
module tb_blk_mem_gen_sdp_ram;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clka = 1'b0;
  logic rsta = 1'b1;
  int   cyc  = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  blk_mem_gen_sdp_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  blk_mem_gen_sdp_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  blk_mem_gen_sdp_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITE_MODE("READ_FIRST"),
    .CLEAR_ON_RESET(1)
  ) dut_a (
    .clka   (clka),
    .rsta   (rsta),
    .mem_if (ifa)
  );

  blk_mem_gen_sdp_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_MODE("WRITE_FIRST"),
    .CLEAR_ON_RESET(1)
  ) dut_b (
    .clka   (clka),
    .rsta   (rsta),
    .mem_if (ifb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic set_inputs(input logic [3:0] we, input logic [AW-1:0] wa, input logic [31:0] wd,
                            input logic re, input logic [AW-1:0] ra);
    ifa.wea = we; ifa.addra = wa; ifa.dina = wd; ifa.enb = re; ifa.addrb = ra;
    ifb.wea = we; ifb.addra = wa; ifb.dina = wd; ifb.enb = re; ifb.addrb = ra;
  endtask

  task automatic drive(input logic [3:0] we, input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic re, input logic [AW-1:0] ra);
    @(posedge clka);
    #1;
    set_inputs(we, wa, wd, re, ra);
  endtask

  task automatic expect_rd(input logic [31:0] ea, input logic [31:0] eb);
    qa.push_back('{data: ea, due: cyc + 1});
    qb.push_back('{data: eb, due: cyc + 2});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
    drive(we, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] ea, input logic [31:0] eb);
    drive(4'h0, '0, 32'h0, 1'b1, a);
    expect_rd(ea, eb);
  endtask

  // Counts edges with init_busy high; optionally fires a write+read at addr 3 mid-sweep.
  task automatic wait_clear(input bit inject, output int na, output int nb);
    int n;
    n  = 0;
    na = 0;
    nb = 0;
    while ((ifa.init_busy || ifb.init_busy) && n < 100) begin
      if (inject && n == 5) set_inputs(4'hF, 4'd3, 32'hCAFEF00D, 1'b1, 4'd3);
      else set_inputs(4'h0, '0, 32'h0, 1'b0, '0);
      if (ifa.init_busy) na++;
      if (ifb.init_busy) nb++;
      @(posedge clka);
      #1;
      n++;
    end
    set_inputs(4'h0, '0, 32'h0, 1'b0, '0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clka);
      if (ifa.doutb_valid === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_valid: doutb=%h at cycle %0d, required no valid",
                   ifa.doutb, cyc);
        end else begin
          e = qa.pop_front();
          if (ifa.doutb !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL a_read: doutb=%h at cycle %0d, required %h at cycle %0d",
                     ifa.doutb, cyc, e.data, e.due);
          end
        end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
        checks++;
        errors++;
        e = qa.pop_front();
        $display("FAIL a_missing_valid: no valid at cycle %0d, required %h", cyc, e.data);
      end
      if (ifb.doutb_valid === 1'b1) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_valid: doutb=%h at cycle %0d, required no valid",
                   ifb.doutb, cyc);
        end else begin
          e = qb.pop_front();
          if (ifb.doutb !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL b_read: doutb=%h at cycle %0d, required %h at cycle %0d",
                     ifb.doutb, cyc, e.data, e.due);
          end
        end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
        checks++;
        errors++;
        e = qb.pop_front();
        $display("FAIL b_missing_valid: no valid at cycle %0d, required %h", cyc, e.data);
      end
    end
  endtask

  initial begin
    int na;
    int nb;
    set_inputs(4'h0, '0, 32'h0, 1'b0, '0);
    fork
      monitor();
    join_none

    // Reset state and clear sweep, with a write/read attempted while busy.
    repeat (3) @(posedge clka);
    #1;
    chk("a_reset_busy", {31'h0, ifa.init_busy}, 32'h1);
    chk("b_reset_busy", {31'h0, ifb.init_busy}, 32'h1);
    chk("a_reset_doutb", ifa.doutb, 32'h0);
    chk("b_reset_doutb", ifb.doutb, 32'h0);
    chk("a_reset_valid", {31'h0, ifa.doutb_valid}, 32'h0);
    rsta = 1'b0;
    wait_clear(1'b1, na, nb);
    chk("a_busy_edges", na, 32'd16);
    chk("b_busy_edges", nb, 32'd16);
    for (int i = 0; i < 16; i++) rd(AW'(i), 32'h0, 32'h0);

    // Byte enables.
    wr(4'd5, 4'hF, 32'hAABBCCDD);
    wr(4'd5, 4'b0101, 32'h11223344);
    rd(4'd5, 32'hAA22CC44, 32'hAA22CC44);

    // Different addresses in the same cycle are independent.
    drive(4'hF, 4'd9, 32'h0BADC0DE, 1'b1, 4'd5);
    expect_rd(32'hAA22CC44, 32'hAA22CC44);
    rd(4'd9, 32'h0BADC0DE, 32'h0BADC0DE);

    // Back-to-back reads: latency and ordering.
    rd(4'd3, 32'h0, 32'h0);
    rd(4'd4, 32'h0, 32'h0);
    rd(4'd5, 32'hAA22CC44, 32'hAA22CC44);

    // Full-word collision on a cleared word.
    drive(4'hF, 4'd7, 32'hDEADBEEF, 1'b1, 4'd7);
    expect_rd(32'h00000000, 32'hDEADBEEF);
    rd(4'd7, 32'hDEADBEEF, 32'hDEADBEEF);

    // Partial-byte collision.
    wr(4'd7, 4'hF, 32'h12345678);
    drive(4'b0011, 4'd7, 32'hFFFFFFFF, 1'b1, 4'd7);
    expect_rd(32'h12345678, 32'h1234FFFF);
    rd(4'd7, 32'h1234FFFF, 32'h1234FFFF);

    // Reset one edge after a read request: the 2-cycle pipe must drop it.
    wr(4'd0, 4'hF, 32'h55AA55AA);
    drive(4'h0, '0, 32'h0, 1'b1, 4'd0);
    qa.push_back('{data: 32'h55AA55AA, due: cyc + 1});
    @(posedge clka);
    #1;
    set_inputs(4'h0, '0, 32'h0, 1'b0, '0);
    rsta = 1'b1;
    @(posedge clka);
    #1;
    rsta = 1'b0;
    chk("a_midreset_doutb", ifa.doutb, 32'h0);
    chk("b_midreset_doutb", ifb.doutb, 32'h0);
    chk("b_midreset_valid", {31'h0, ifb.doutb_valid}, 32'h0);
    wait_clear(1'b0, na, nb);
    chk("b_reclear_edges", nb, 32'd16);
    rd(4'd0, 32'h0, 32'h0);
    rd(4'd9, 32'h0, 32'h0);

    repeat (5) drive(4'h0, '0, 32'h0, 1'b0, '0);
    chk("a_queue_drained", qa.size(), 32'h0);
    chk("b_queue_drained", qb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
